// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame serializer: FSM state type,
// parity-mode constants and the default data width.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/parity_acc.sv
// One-bit parity accumulator: synchronous load, XOR-toggle when enabled,
// asynchronous active-low reset to EVEN.
module parity_acc
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_val,
  input  logic xor_en,
  input  logic xor_bit,
  output logic acc
);

  logic acc_d;
  logic acc_q;

  // Load wins over accumulate so a new frame always starts from its mode bit.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = load_val;
    end else if (xor_en) begin
      acc_d = acc_q ^ xor_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= EVEN;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Serializes DATA_W-bit words LSB first followed by an EVEN/ODD parity bit.
// Optional 8-bit completed-frame counter enabled by PARITY_FRAME_CNT_EN.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_mode,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_done,
  output logic              busy
`ifdef PARITY_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state_d, state_q;
  logic [DATA_W-1:0] shift_d, shift_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic              acc;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_data;
          idx_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = PARITY;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      PARITY:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Accumulator starts at the mode bit, so after all data bits it already holds the parity.
  parity_acc u_parity_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (odd_mode),
    .xor_en   (state_q == SHIFT),
    .xor_bit  (shift_q[0]),
    .acc      (acc)
  );

  // Outputs decode directly from state so reset clears them without waiting for a clock.
  always_comb begin
    ser_out = 1'b0;
    if (state_q == SHIFT) begin
      ser_out = shift_q[0];
    end else if (state_q == PARITY) begin
      ser_out = acc;
    end
  end

  assign ser_valid  = (state_q == SHIFT) || (state_q == PARITY);
  assign frame_done = (state_q == DONE);
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

`ifdef PARITY_FRAME_CNT_EN
  logic [7:0] frame_cnt_d, frame_cnt_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == DONE) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: directed scenarios plus
// randomized frames against a ones-count parity model.
module tb_parity_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         odd_mode = 1'b0;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_done;
  logic         busy;
`ifdef PARITY_FRAME_CNT_EN
  logic [7:0]   frame_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic ser_q[$];
  int   done_cnt = 0;
  int   cyc = 0;
  int   acc_cyc[$];

  parity_frame_ctrl #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .odd_mode   (odd_mode),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef PARITY_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ser_valid) ser_q.push_back(ser_out);
    if (frame_done) done_cnt++;
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  // Reference: data LSB first, then the bit that makes the ones count even (EVEN) or odd (ODD).
  function automatic logic [W:0] exp_frame(input logic [W-1:0] d, input logic om);
    int ones;
    ones = $countones(d);
    exp_frame = {1'(((ones + int'(om)) % 2)), d};
  endfunction

  function automatic logic [W:0] observed(input int base);
    logic [W:0] v;
    v = '0;
    for (int i = 0; i <= W; i++) begin
      if (base + i < ser_q.size()) v[i] = ser_q[base + i];
    end
    return v;
  endfunction

  task automatic start_frame(input logic [W-1:0] d, input logic om, output bit to);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    odd_mode = om;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    to = !in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit to);
    int n;
    n = 0;
    while (done_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    to = (done_cnt < target);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ser_out, ser_valid, frame_done, busy, in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_outputs: got out/vld/done/busy/rdy=%b want 00001",
               {ser_out, ser_valid, frame_done, busy, in_ready});
    end
`ifdef PARITY_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ser_valid, busy, in_ready} !== 3'b001) begin
      bad++;
      $display("FAIL post_reset_idle: got vld/busy/rdy=%b want 001", {ser_valid, busy, in_ready});
    end
  endtask

  task automatic test_a5_even();
    bit to1, to2;
    int d0;
    logic [W:0] exp;
    logic [W:0] lit;
    ser_q.delete();
    d0 = done_cnt;
    start_frame(8'hA5, 1'b0, to1);
    wait_done(d0 + 1, to2);
    repeat (3) @(negedge clk);
    exp = exp_frame(8'hA5, 1'b0);
    lit = 9'b0_1010_0101;
    total++;
    if (to1 || to2) begin
      bad++;
      $display("FAIL a5_even_timeout: accept_to=%0d done_to=%0d want 0 0", to1, to2);
    end
    total++;
    if (ser_q.size() != W + 1 || observed(0) !== exp || exp !== lit) begin
      bad++;
      $display("FAIL a5_even_bits: got n=%0d bits=%b want n=%0d bits=%b", ser_q.size(), observed(0), W + 1, lit);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL a5_even_done: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_odd_and_01();
    bit to1, to2;
    int d0;
    ser_q.delete();
    d0 = done_cnt;
    start_frame(8'hA5, 1'b1, to1);
    wait_done(d0 + 1, to2);
    start_frame(8'h01, 1'b0, to1);
    wait_done(d0 + 2, to2);
    total++;
    if (ser_q.size() != 2 * (W + 1) || observed(0) !== exp_frame(8'hA5, 1'b1) || ser_q[W] !== 1'b1) begin
      bad++;
      $display("FAIL a5_odd_bits: got %b want %b", observed(0), exp_frame(8'hA5, 1'b1));
    end
    total++;
    if (observed(W + 1) !== exp_frame(8'h01, 1'b0) || ser_q[2 * W + 1] !== 1'b1) begin
      bad++;
      $display("FAIL 01_even_bits: got %b want %b", observed(W + 1), exp_frame(8'h01, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int d0, n;
    ser_q.delete();
    acc_cyc.delete();
    d0 = done_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h0F;
    odd_mode = 1'b0;
    n = 0;
    while (acc_cyc.size() < 1 && n < 50) begin @(negedge clk); n++; end
    in_data = 8'hF0;
    n = 0;
    while (acc_cyc.size() < 2 && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b0;
    wait_done(d0 + 2, to);
    total++;
    if (acc_cyc.size() != 2 || to) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d accepts done_to=%0d want 2 0", acc_cyc.size(), to);
    end else begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != W + 3) begin
        bad++;
        $display("FAIL b2b_spacing: got %0d cycles want %0d", acc_cyc[1] - acc_cyc[0], W + 3);
      end
    end
    total++;
    if (ser_q.size() != 2 * (W + 1) || observed(0) !== exp_frame(8'h0F, 1'b0) ||
        observed(W + 1) !== exp_frame(8'hF0, 1'b0) || ser_q[W] !== 1'b0 || ser_q[2 * W + 1] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_bits: got %b %b want %b %b", observed(0), observed(W + 1),
               exp_frame(8'h0F, 1'b0), exp_frame(8'hF0, 1'b0));
    end
  endtask

  task automatic test_ignore_mid_frame(input int frames);
    bit to1, to2;
    int d0, rdy_bad;
    logic [W-1:0] d;
    logic om;
    for (int f = 0; f < frames; f++) begin
      d  = W'($urandom);
      om = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ser_q.delete();
      d0 = done_cnt;
      rdy_bad = 0;
      start_frame(d, om, to1);
      for (int i = 0; i <= W; i++) begin
        if (in_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
        in_data  = W'($urandom);
        odd_mode = (f == 0) ? ~odd_mode : 1'($urandom);
        in_valid = (i == W) ? 1'b0 : 1'($urandom);
        @(negedge clk);
      end
      wait_done(d0 + 1, to2);
      total++;
      if (to1 || to2 || rdy_bad != 0) begin
        bad++;
        $display("FAIL mid_frame_ready[%0d]: ready_high_cycles=%0d timeouts=%0d%0d want 0 00", f, rdy_bad, to1, to2);
      end
      total++;
      if (ser_q.size() != W + 1 || observed(0) !== exp_frame(d, om)) begin
        bad++;
        $display("FAIL mid_frame_bits[%0d]: got n=%0d %b want %b (data=%h odd=%0d)",
                 f, ser_q.size(), observed(0), exp_frame(d, om), d, om);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit to1, to2;
    int d0, qlen;
    ser_q.delete();
    d0 = done_cnt;
    start_frame(8'hA5, 1'b1, to1);
    repeat (3) @(negedge clk);
    #2;
    qlen = ser_q.size();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ser_out, ser_valid, frame_done, busy, in_ready} !== 5'b00001 || qlen != 4) begin
      bad++;
      $display("FAIL async_reset: got out/vld/done/busy/rdy=%b bits_before=%0d want 00001 4",
               {ser_out, ser_valid, frame_done, busy, in_ready}, qlen);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if (done_cnt != d0 || ser_q.size() != qlen) begin
      bad++;
      $display("FAIL abandoned_frame: got done=%0d bits=%0d want done=%0d bits=%0d",
               done_cnt - d0, ser_q.size(), 0, qlen);
    end
    ser_q.delete();
    start_frame(8'h3C, 1'b0, to1);
    wait_done(d0 + 1, to2);
    total++;
    if (to1 || to2 || ser_q.size() != W + 1 || observed(0) !== exp_frame(8'h3C, 1'b0) || ser_q[W] !== 1'b0) begin
      bad++;
      $display("FAIL 3c_after_reset: got n=%0d %b want %b", ser_q.size(), observed(0), exp_frame(8'h3C, 1'b0));
    end
  endtask

`ifdef PARITY_FRAME_CNT_EN
  task automatic test_frame_cnt();
    bit to;
    int d0, n;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_cyc.delete();
    d0 = done_cnt;
    in_valid = 1'b1;
    n = 0;
    while (acc_cyc.size() < 257 && n < 257 * (W + 3) + 50) begin
      @(negedge clk);
      in_data  = W'($urandom);
      odd_mode = 1'($urandom);
      n++;
    end
    in_valid = 1'b0;
    wait_done(d0 + 257, to);
    repeat (3) @(negedge clk);
    total++;
    if (to || done_cnt - d0 != 257 || frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL frame_cnt_wrap: got cnt=%0d frames=%0d want cnt=1 frames=257", frame_cnt, done_cnt - d0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a5_even();
    test_odd_and_01();
    test_back_to_back();
    test_ignore_mid_frame(20);
    test_reset_mid_frame();
`ifdef PARITY_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
